// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: start/stop checking, byte handoff via level-valid + ack, overrun and framing status.
// Latency: RX falling edge to RX_READY high is 2 + H + 9*B + 1 cycles (B = clocks per bit, H = B/2).
// No backpressure on the wire: an unacknowledged byte is overwritten by the next good byte and OVERRUN is raised.
module uart_rx_frame (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [19:0] BAUD_DIV,
  input  logic        RX,
  input  logic        RX_ACK,
  output logic [7:0]  DATA_OUT,
  output logic        RX_READY,
  output logic        OVERRUN,
  output logic        FRAME_ERR
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic        r_sync1;
  logic        r_sync2;
  logic [2:0]  r_state;
  logic [19:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [19:0] r_b;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_ready;
  logic        r_ovr;
  logic        r_ferr;

  logic        w_rx_s;
  logic [19:0] w_b_eff;
  logic [19:0] w_h;
  logic        w_half_done;
  logic        w_bit_done;
  logic        w_commit;
  logic        w_ferr_evt;

  // Synchronized line, effective divider (floor of 2) and the bit-timing strobes.
  assign w_rx_s      = r_sync2;
  assign w_b_eff     = (BAUD_DIV < 20'd2) ? 20'd2 : BAUD_DIV;
  assign w_h         = r_b >> 1;
  assign w_half_done = (r_cnt == (w_h - 20'd1));
  assign w_bit_done  = (r_cnt == (r_b - 20'd1));
  assign w_commit    = (r_state == S_STOP) && w_bit_done && w_rx_s;
  assign w_ferr_evt  = (r_state == S_STOP) && w_bit_done && !w_rx_s;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: one counter, cleared on every state entry and after each data sample.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= 20'd0;
      r_bit_idx <= 3'd0;
      r_b       <= 20'd2;
      r_shift   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 20'd0;
          if (!w_rx_s) begin
            // Divider is frozen here so mid-frame changes cannot skew sampling.
            r_b     <= w_b_eff;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_half_done) begin
            r_cnt     <= 20'd0;
            r_bit_idx <= 3'd0;
            // A start bit that is high again at mid-bit was a glitch.
            r_state   <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_cnt     <= 20'd0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_cnt   <= 20'd0;
            r_state <= w_rx_s ? S_IDLE : S_BREAK;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_BREAK: begin
          // Hold off until the line recovers so a break yields a single error.
          r_cnt <= 20'd0;
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= 20'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Consumer handshake: a commit beats a simultaneous ack; ack alone clears both flags.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_data  <= 8'h00;
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_commit) begin
      r_data  <= r_shift;
      r_ready <= 1'b1;
      if (RX_ACK) begin
        r_ovr <= 1'b0;
      end else if (r_ready) begin
        r_ovr <= 1'b1;
      end
    end else if (RX_ACK) begin
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  // Framing error is a single-cycle strobe on a low stop sample.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ferr <= 1'b0;
    end else begin
      r_ferr <= w_ferr_evt;
    end
  end

  assign DATA_OUT  = r_data;
  assign RX_READY  = r_ready;
  assign OVERRUN   = r_ovr;
  assign FRAME_ERR = r_ferr;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: random and directed 8N1 frames scored against a frame-level model.
// Expected commit/error cycles come from the bit-period arithmetic, not from the design's internals.
// The consumer acks at chosen points, including the exact commit cycle.
module tb_uart_rx_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] baud;
  logic        rx;
  logic        ack;
  logic [7:0]  dout;
  logic        rdy;
  logic        ovr;
  logic        ferr;

  uart_rx_frame dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .BAUD_DIV (baud),
    .RX       (rx),
    .RX_ACK   (ack),
    .DATA_OUT (dout),
    .RX_READY (rdy),
    .OVERRUN  (ovr),
    .FRAME_ERR(ferr)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_ferr;
    logic [7:0] d;
    bit         rdy;
    bit         ovr;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  // Frame-level model of the consumer-visible state.
  bit         m_rdy;
  bit         m_ovr;
  logic [7:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame, LSB first; the stop level is selectable and left on the line.
  task automatic send_bits(input logic [7:0] d, input int b, input logic stop_v, input bit scramble);
    rx = 1'b0;
    tick(b);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(b);
      if (i == 0 && scramble) baud = 20'($urandom_range(0, 24));
    end
    rx = stop_v;
    tick(b);
  endtask

  // Good frame: predict the commit cycle and flags, then transmit (optionally acking on the commit edge).
  task automatic issue(input logic [7:0] d, input logic [19:0] bd, input bit collide, input bit scramble);
    int b, h, n;
    exp_t e;
    b = (bd < 20'd2) ? 2 : int'(bd);
    h = b / 2;
    baud = bd;
    n = cyc;
    e.is_ferr = 1'b0;
    e.d       = d;
    e.rdy     = 1'b1;
    e.ovr     = collide ? 1'b0 : m_rdy;
    e.cyc     = n + 3 + h + 9 * b;
    m_rdy  = 1'b1;
    m_ovr  = e.ovr;
    m_last = d;
    sb.push_back(e);
    fork
      send_bits(d, b, 1'b1, scramble);
      if (collide) begin
        tick(2 + h + 9 * b);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
      end
    join
  endtask

  // Bad stop bit followed by a long break, then the line returns high.
  task automatic issue_ferr(input logic [19:0] bd);
    int b, h, n;
    exp_t e;
    b = (bd < 20'd2) ? 2 : int'(bd);
    h = b / 2;
    baud = bd;
    n = cyc;
    e.is_ferr = 1'b1;
    e.d       = 8'h00;
    e.rdy     = m_rdy;
    e.ovr     = m_ovr;
    e.cyc     = n + 3 + h + 9 * b;
    sb.push_back(e);
    send_bits(8'h00, b, 1'b0, 1'b0);
    tick(40 * b);
    rx = 1'b1;
    tick(2 * b);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    chk("ack_clears_ready", rdy, m_rdy);
    chk("ack_clears_overrun", ovr, m_ovr);
  endtask

  // Monitor: any new byte presentation or framing strobe pops and checks one prediction.
  bit         prev_rdy = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ferr === 1'b1 || (rdy === 1'b1 && (!prev_rdy || dout !== prev_dat))) begin
        chk("evt_pending", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("evt_kind_ferr", ferr, mon_e.is_ferr);
          chk("evt_cycle", cyc, mon_e.cyc);
          chk("evt_ready", rdy, mon_e.rdy);
          chk("evt_overrun", ovr, mon_e.ovr);
          if (!mon_e.is_ferr) chk("evt_data", dout, mon_e.d);
        end
      end
    end
    prev_rdy = rdy;
    prev_dat = dout;
  end

  initial begin
    logic [7:0] pb;
    logic [7:0] d;
    logic [19:0] bd;
    int r;
    bit scr;

    rst_n  = 1'b0;
    rx     = 1'b1;
    ack    = 1'b0;
    baud   = 20'd16;
    m_rdy  = 1'b0;
    m_ovr  = 1'b0;
    m_last = 8'h00;
    tick(3);
    chk("reset_data", dout, 8'h00);
    chk("reset_ready", rdy, 1'b0);
    chk("reset_overrun", ovr, 1'b0);
    chk("reset_ferr", ferr, 1'b0);
    rst_n = 1'b1;
    tick(3);

    // Single frame at B=16.
    issue(8'hA5, 20'd16, 1'b0, 1'b0);
    tick(4);
    chk("single_data", dout, 8'hA5);
    chk("single_overrun", ovr, 1'b0);
    ack_pulse();

    // Back-to-back frames without ack: overrun.
    issue(8'h3C, 20'd16, 1'b0, 1'b0);
    issue(8'hC3, 20'd16, 1'b0, 1'b0);
    tick(4);
    chk("b2b_data", dout, 8'hC3);
    chk("b2b_ready", rdy, 1'b1);
    chk("b2b_overrun", ovr, 1'b1);
    ack_pulse();

    // Ack in the same cycle as the second commit.
    issue(8'h11, 20'd16, 1'b0, 1'b0);
    issue(8'h99, 20'd16, 1'b1, 1'b0);
    tick(4);
    chk("collide_data", dout, 8'h99);
    chk("collide_ready", rdy, 1'b1);
    chk("collide_overrun", ovr, 1'b0);

    // Framing error plus break with a byte still held.
    issue_ferr(20'd16);
    chk("break_ready_kept", rdy, m_rdy);
    chk("break_data_kept", dout, m_last);
    issue(8'h55, 20'd16, 1'b0, 1'b0);
    tick(4);
    chk("after_break_data", dout, 8'h55);
    ack_pulse();

    // Short start glitch, then a real frame.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(12);
    chk("glitch_no_ready", rdy, 1'b0);
    issue(8'h81, 20'd16, 1'b0, 1'b0);
    tick(4);
    chk("glitch_next_data", dout, 8'h81);

    // Reset during data bit 4 while a byte is held.
    pb = 8'h7E;
    baud = 20'd16;
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = pb[i];
      tick(16);
    end
    rx = pb[4];
    tick(8);
    rst_n = 1'b0;
    rx = 1'b1;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    m_last = 8'h00;
    tick(1);
    chk("midreset_data", dout, 8'h00);
    chk("midreset_ready", rdy, 1'b0);
    chk("midreset_overrun", ovr, 1'b0);
    chk("midreset_ferr", ferr, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("post_reset_idle_ready", rdy, 1'b0);
    issue(8'h7E, 20'd16, 1'b0, 1'b0);
    tick(4);
    chk("post_reset_data", dout, 8'h7E);
    ack_pulse();

    // Divider below the floor behaves as 2.
    issue(8'h7E, 20'd0, 1'b0, 1'b0);
    tick(4);
    chk("min_div_data", dout, 8'h7E);
    ack_pulse();

    // Random frames, dividers, gaps and ack patterns.
    for (int k = 0; k < 40; k++) begin
      bd = 20'($urandom_range(0, 24));
      d = 8'($urandom_range(0, 255));
      while (d == m_last) d = 8'($urandom_range(0, 255));
      scr = 1'($urandom_range(0, 1));
      issue(d, bd, 1'b0, scr);
      r = $urandom_range(0, 3);
      if (r != 0) begin
        tick(4);
        if (r >= 2) ack_pulse();
      end
    end

    tick(8);
    for (int k = 0; k < 2000 && sb.size() != 0; k++) tick(1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

8N1 UART receiver that samples a serial line, checks start and stop bits, and delivers each good byte through a level-valid / acknowledge handshake. It sits on the receive side of the board-level UART link, facing the existing transmitter across a GPIO pin. It drives LED or consumer logic, with framing-error and overrun status, so that byte loss on the link is visible.

## Interface
- No parameters. Bit period is a run-time input, matching the transmitter's `baudRate` convention of clocks per bit.
- `CLOCK_50`  in  1  system clock. This is the only clock.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `BAUD_DIV`  in  20  clocks per bit. Values below 2 are treated as 2. Latched at frame start.
- `RX`  in  1  serial line, asynchronous to `CLOCK_50`. Idle level is high.
- `RX_ACK`  in  1  consumer acknowledge. Clears `RX_READY` and `OVERRUN`.
- `DATA_OUT`  out  8  last good byte received, LSB first on the wire.
- `RX_READY`  out  1  high while an unacknowledged good byte is held.
- `OVERRUN`  out  1  sticky. A good byte arrived while `RX_READY` was already high.
- `FRAME_ERR`  out  1  one-cycle pulse when the stop bit samples low.

## Operation
- **Synchronizer:** 2-FF synchronizer on `RX` produces `rx_s`. Both flops reset to 1. All FSM decisions use `rx_s`.
- **Bit timing:** `B` = max(`BAUD_DIV`, 2), latched when leaving IDLE. `H` = `B` >> 1. A single cycle counter, cleared on every state entry, times each bit.
- **IDLE:** on `rx_s`=0, latch `B` and go to START.
- **START:** sample `rx_s` after `H` cycles.
  - If 0: valid start. Go to DATA with bit index 0.
  - If 1: glitch. Return to IDLE silently with no outputs changed.
- **DATA:** sample every `B` cycles into the shift register, LSB first. After bit index 7, go to STOP.
- **STOP:** sample after `B` cycles.
  - If 1: commit the shift register to `DATA_OUT`, set `RX_READY`, go to IDLE.
  - If 0: pulse `FRAME_ERR`, leave `DATA_OUT`, `RX_READY` and `OVERRUN` unchanged, go to BREAK.
- **BREAK:** wait until `rx_s`=1, then go to IDLE. A held-low line (break) therefore yields exactly one `FRAME_ERR` and no spurious frames.
- **Handshake:**
  - `RX_ACK` clears `RX_READY` and `OVERRUN` on the next edge.
  - A commit while `RX_READY`=1 and `RX_ACK`=0 overwrites `DATA_OUT` and sets `OVERRUN`.
  - A commit in the same cycle as `RX_ACK`: the commit wins. `RX_READY` stays 1, `DATA_OUT` takes the new byte, `OVERRUN` is cleared (the old byte was consumed).
  - `RX_ACK` while `RX_READY`=0 has no effect.
- **Reset** (asserted at any time, including mid-frame):
  - Outputs: `DATA_OUT`=0x00, `RX_READY`=0, `OVERRUN`=0, `FRAME_ERR`=0.
  - Internal: FSM in IDLE, counter and bit index 0, sync flops 1.
  - A partial frame is discarded. After release, reception restarts only on the next falling edge of `rx_s`.
- **Mid-frame `BAUD_DIV` change:** ignored until the next IDLE→START transition.

## Timing
- `rx_s` lags `RX` by 2 `CLOCK_50` edges.
- Let t0 be the first cycle with `rx_s`=0 in IDLE. Sample points:
  - start bit at t0+`H`;
  - data bit i (0..7) at t0+`H`+(i+1)·`B`;
  - stop bit at t0+`H`+9·`B`.
- `DATA_OUT` and `RX_READY` update, or `FRAME_ERR` pulses, on the edge after the stop sample. Total latency from the `RX` falling edge to `RX_READY` high is 2+`H`+9·`B`+1 cycles.
- FSM returns to IDLE in the same cycle the result appears. A next start bit arriving half a bit after the stop-bit midpoint is accepted, so back-to-back frames work with no inter-frame gap beyond the stop bit.
- `FRAME_ERR` is high for exactly 1 cycle per bad frame.
- Tolerated sender/receiver rate mismatch: ±4% at `B` ≥ 16.

## Test plan
- **Single frame:** `B`=16, send 0xA5 as 8N1. Required: `RX_READY` rises 2+8+144+1 = 155 cycles after the `RX` falling edge, `DATA_OUT`=0xA5, `OVERRUN`=0, `FRAME_ERR` never high.
- **Back-to-back with overrun:** send 0x3C then 0xC3 back-to-back with no `RX_ACK`. Required: `DATA_OUT`=0xC3, `RX_READY`=1, `OVERRUN`=1. One `RX_ACK` then clears both flags on the next edge.
- **ACK/commit collision:** assert `RX_ACK` in the exact cycle the second byte commits. Required: `RX_READY`=1, `OVERRUN`=0, `DATA_OUT` = second byte.
- **Framing error and break:** stop bit forced low with payload 0x00, then the line held low for 40·`B`. Required: exactly one `FRAME_ERR` pulse, `RX_READY` unchanged. A following valid 0x55 after the line returns high is received correctly.
- **Start glitch:** 3-cycle low glitch on `RX` with `B`=16. Required: no `RX_READY` and no `FRAME_ERR`, FSM back in IDLE. An immediately following valid frame 0x81 is received.
- **Reset mid-frame and minimum divider:**
  - Assert `RESET_N` low during data bit 4. Required: all outputs at reset values. After release, the next full frame 0x7E is received.
  - Repeat 0x7E with `BAUD_DIV`=0. Required: behaves as `B`=2 and receives 0x7E.
